oam_dma: RTL
============

# oam_dma

Sprite-attribute DMA and OAM port controller for the NES core. It decodes CPU writes to $2003 (OAMADDR), $2004 (OAMDATA) and $4014 (OAMDMA). On a $4014 write it halts the CPU and copies one 256-byte page from CPU address space into the 256-byte OAM array, which the PPU then reads through its sprite cursor. It sits between the CPU bus and the OAM write port, upstream of the PPU sprite fetch.

## Interface
Parameters:
- OAMADDR_REG, 16'h2003, CPU address of the OAM pointer register
- OAMDATA_REG, 16'h2004, CPU address of the OAM data port
- OAMDMA_REG, 16'h4014, CPU address of the DMA trigger

Ports:
- pin_clock  in  1  system clock (25 MHz); single clock domain
- pin_reset  in  1  asynchronous, active-high reset
- pin_ce  in  1  CPU cycle enable; every state step and counter is qualified by it
- cpu_address  in  16  CPU bus address
- cpu_o  in  8  CPU write data
- cpu_w  in  1  CPU write strobe, sampled only when pin_ce=1
- dma_active  out  1  high while DMA owns the bus; the CPU must be stalled and the memory address muxed to dma_address
- dma_address  out  16  DMA read address {page, index}
- dma_i  in  8  memory read data, valid one pin_clock after dma_address
- oam_address  out  8  OAM write address
- oam_data  out  8  OAM write data
- oam_w  out  1  OAM write strobe, one pin_clock wide

## Operation
- Registers: page[7:0], index[7:0], oam_ptr[7:0] and parity (toggles on every pin_ce cycle).
- FSM states: IDLE, WAIT, ALIGN, READ, WRITE. All transitions occur only on pin_ce=1.
- IDLE:
  - cpu_w & $2003: oam_ptr <= cpu_o.
  - cpu_w & $2004: issue an OAM write of cpu_o at oam_ptr, then oam_ptr++ (mod 256).
  - cpu_w & $4014: page <= cpu_o, index <= 0, go to WAIT.
- WAIT: one dummy cycle. If parity was 1 at the $4014 write cycle, go to ALIGN; otherwise go to READ.
- ALIGN: one extra dummy cycle, then go to READ.
- READ: drive dma_address={page,index}, go to WRITE.
- WRITE: oam_data<=dma_i, oam_address<=oam_ptr+index (8-bit wrap), pulse oam_w. Then:
  - if index==8'hFF, go to IDLE;
  - else index++ and go to READ.
- oam_ptr is not modified by DMA; after 256 increments it would wrap to the same value anyway.
- dma_active=1 in WAIT, ALIGN, READ and WRITE.
- dma_address=0 outside READ/WRITE. In WRITE it holds the READ value.
- While dma_active, all CPU writes ($2003, $2004, $4014) are ignored.
- Other CPU addresses are ignored in every state.

## Timing
- Reset (asynchronous): state=IDLE, dma_active=0, dma_address=0, oam_w=0, oam_address=0, oam_data=0, oam_ptr=0, index=0, page=0, parity=0.
- Reset mid-DMA aborts immediately. No further oam_w pulses; bytes already written stay in OAM.
- dma_active rises on the pin_clock edge of the $4014 write cycle. It falls on the edge of the final WRITE cycle.
- DMA length: 513 pin_ce cycles (even parity) or 514 (odd parity), counting from the cycle after the $4014 write.
- oam_w, oam_address and oam_data are registered. They assert on the edge ending a WRITE cycle (or a $2004 write cycle) and drop after exactly one pin_clock, regardless of pin_ce.
- dma_i is sampled in WRITE. Memory read latency is one pin_clock, so READ→WRITE works with pin_ce high continuously or throttled.
- Throttled pin_ce: FSM, index and parity freeze on pin_ce=0 cycles; outputs hold except oam_w, which still clears after one clock.

## Test plan
1. $2003←10, then $4014←02 at parity 0, memory[0x0200+i]=i^0x5A:
   - OAM[(0x10+i)&FF]=i^0x5A for all i; OAM[0x0F]=0xFF^0x5A;
   - dma_active high for exactly 513 ce cycles; exactly 256 oam_w pulses.
2. Same as scenario 1 with the $4014 write at parity 1 → dma_active high for 514 ce cycles; same OAM contents.
3. $2003←FE, then $2004←AA, BB, CC → OAM[FE]=AA, OAM[FF]=BB, OAM[00]=CC; oam_ptr=01; dma_active stays 0.
4. Assert pin_reset after 100 oam_w pulses of a DMA:
   - dma_active=0 and oam_w=0 the same instant;
   - OAM[0..99] written, OAM[100..] untouched;
   - a subsequent $2004 write lands at OAM[00].
5. pin_ce high 1 cycle in 4 during scenario 1 → identical OAM contents; 513 ce cycles (2052 pin_clock); oam_w pulses 1 pin_clock wide.
6. During an active DMA, CPU writes $4014←07 and $2003←33 → both ignored; DMA completes page 02; oam_ptr unchanged.

Source files
------------

// File: rtl/oam_dma_if.sv
// oam_dma_if
//   Groups the CPU write bus, the DMA memory-read port and the OAM write
//   port used by oam_dma.
//   master : the OAM/DMA controller (samples the CPU bus and read data,
//            drives dma_active, dma_address and the OAM write port)
//   slave  : the surrounding CPU/memory/OAM side
//   Signals:
//     cpu_address[15:0], cpu_o[7:0], cpu_w : CPU write bus
//     dma_active, dma_address[15:0]        : bus ownership and read address
//     dma_i[7:0]                           : memory read data (1 clock latency)
//     oam_address[7:0], oam_data[7:0], oam_w : OAM write port
interface oam_dma_if;
    logic [15:0] cpu_address;
    logic [7:0]  cpu_o;
    logic        cpu_w;
    logic        dma_active;
    logic [15:0] dma_address;
    logic [7:0]  dma_i;
    logic [7:0]  oam_address;
    logic [7:0]  oam_data;
    logic        oam_w;

    modport master (
        input  cpu_address, cpu_o, cpu_w, dma_i,
        output dma_active, dma_address, oam_address, oam_data, oam_w
    );

    modport slave (
        output cpu_address, cpu_o, cpu_w, dma_i,
        input  dma_active, dma_address, oam_address, oam_data, oam_w
    );
endinterface

// File: rtl/oam_dma.sv
// oam_dma
//   Sprite-attribute DMA and OAM port controller. Decodes CPU writes to
//   OAMADDR / OAMDATA / OAMDMA. A write to OAMDMA stalls the CPU
//   (dma_active) and copies one 256-byte page of CPU space into OAM,
//   starting at the current OAM pointer.
//   Ports:
//     pin_clock : system clock
//     pin_reset : asynchronous active-high reset
//     pin_ce    : CPU cycle enable; qualifies every state step and counter
//     bus       : oam_dma_if.master (CPU bus, DMA read port, OAM write port)
module oam_dma #(
    parameter logic [15:0] OAMADDR_REG = 16'h2003,
    parameter logic [15:0] OAMDATA_REG = 16'h2004,
    parameter logic [15:0] OAMDMA_REG  = 16'h4014
) (
    input logic        pin_clock,
    input logic        pin_reset,
    input logic        pin_ce,
    oam_dma_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ALIGN,
        S_READ,
        S_WRITE
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] page_q, page_d;
    logic [7:0] index_q, index_d;
    logic [7:0] oam_ptr_q, oam_ptr_d;
    logic       parity_q, parity_d;
    // parity captured on the OAMDMA write; selects the extra ALIGN cycle
    logic       align_q, align_d;
    logic       oam_w_q, oam_w_d;
    logic [7:0] oam_address_q, oam_address_d;
    logic [7:0] oam_data_q, oam_data_d;

    // State register
    always_ff @(posedge pin_clock or posedge pin_reset) begin
        if (pin_reset) begin
            state_q       <= S_IDLE;
            page_q        <= '0;
            index_q       <= '0;
            oam_ptr_q     <= '0;
            parity_q      <= 1'b0;
            align_q       <= 1'b0;
            oam_w_q       <= 1'b0;
            oam_address_q <= '0;
            oam_data_q    <= '0;
        end else begin
            state_q       <= state_d;
            page_q        <= page_d;
            index_q       <= index_d;
            oam_ptr_q     <= oam_ptr_d;
            parity_q      <= parity_d;
            align_q       <= align_d;
            oam_w_q       <= oam_w_d;
            oam_address_q <= oam_address_d;
            oam_data_q    <= oam_data_d;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d       = state_q;
        page_d        = page_q;
        index_d       = index_q;
        oam_ptr_d     = oam_ptr_q;
        parity_d      = parity_q;
        align_d       = align_q;
        // strobe defaults low so it lasts one pin_clock even when pin_ce is low
        oam_w_d       = 1'b0;
        oam_address_d = oam_address_q;
        oam_data_d    = oam_data_q;

        if (pin_ce) begin
            parity_d = ~parity_q;
            case (state_q)
                S_IDLE: begin
                    if (bus.cpu_w) begin
                        if (bus.cpu_address == OAMADDR_REG) begin
                            oam_ptr_d = bus.cpu_o;
                        end else if (bus.cpu_address == OAMDATA_REG) begin
                            oam_w_d       = 1'b1;
                            oam_address_d = oam_ptr_q;
                            oam_data_d    = bus.cpu_o;
                            oam_ptr_d     = oam_ptr_q + 8'd1;
                        end else if (bus.cpu_address == OAMDMA_REG) begin
                            page_d  = bus.cpu_o;
                            index_d = '0;
                            align_d = parity_q;
                            state_d = S_WAIT;
                        end
                    end
                end
                S_WAIT:  state_d = align_q ? S_ALIGN : S_READ;
                S_ALIGN: state_d = S_READ;
                S_READ:  state_d = S_WRITE;
                S_WRITE: begin
                    oam_w_d       = 1'b1;
                    oam_data_d    = bus.dma_i;
                    oam_address_d = oam_ptr_q + index_q;
                    if (index_q == 8'hFF) begin
                        state_d = S_IDLE;
                    end else begin
                        index_d = index_q + 8'd1;
                        state_d = S_READ;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Outputs
    always_comb begin
        bus.dma_active  = (state_q != S_IDLE);
        bus.dma_address = '0;
        if (state_q == S_READ || state_q == S_WRITE) begin
            bus.dma_address = {page_q, index_q};
        end
        bus.oam_w       = oam_w_q;
        bus.oam_address = oam_address_q;
        bus.oam_data    = oam_data_q;
    end

endmodule
